pipe_mem_arbiter: RTL and testbench
===================================

PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive MEM grants tolerated while IF waits.
REQ-002 Parameter TIMEOUT, default 15: cycles to wait for m_ack before declaring error.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  instruction fetch request; read-only.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_abort  in  1  taken branch/jump; cancels delivery of the current fetch.
REQ-008 if_ack  out  1  one-cycle pulse; if_rdata valid.
REQ-009 if_rdata  out  32  fetched instruction, registered.
REQ-010 mem_req  in  1  data access request.
REQ-011 mem_we  in  1  1 = store, 0 = load.
REQ-012 mem_addr  in  32  data byte address.
REQ-013 mem_wdata  in  32  store data.
REQ-014 mem_ack  out  1  one-cycle pulse; mem_rdata valid for loads.
REQ-015 mem_rdata  out  32  load data, registered.
REQ-016 stall_if  out  1  = if_req & ~if_ack; drives PC/IF_ID hold.
REQ-017 stall_mem  out  1  = mem_req & ~mem_ack; freezes the whole pipeline.
REQ-018 m_req, m_we, m_addr[32], m_wdata[32]  out  shared single-port memory command, registered.
REQ-019 m_ack  in  1  memory completion pulse; m_rdata[32] in valid with it.
REQ-020 err  out  1  sticky timeout flag.

Function
REQ-021 States IDLE, BUSY_IF, BUSY_MEM, RESP; one transaction in flight at most.
REQ-022 IDLE: mem_req pending and starve_cnt < STARVE_LIMIT -> BUSY_MEM; else if_req -> BUSY_IF; else mem_req -> BUSY_MEM; none -> stay.
REQ-023 On the grant edge, m_req=1 and m_we/m_addr/m_wdata latch from the granted requester; they hold constant until m_ack.
REQ-024 BUSY_x: on m_ack, capture m_rdata into x_rdata, drop m_req, go to RESP; requester ack asserted during RESP only.
REQ-025 RESP: exactly one cycle, no arbitration, then IDLE; minimum request-to-ack latency is 2 cycles with m_ack on the first BUSY cycle.
REQ-026 starve_cnt (2 bits, saturating): +1 on each MEM grant while if_req=1; cleared on IF grant or when if_req=0 in IDLE.
REQ-027 Requesters hold req/addr/we/wdata stable until their ack; the arbiter samples only at grant.
REQ-028 if_abort during BUSY_IF or its RESP: the memory read completes, but if_ack is suppressed; if_abort in IDLE has no effect.
REQ-029 MEM transactions are never aborted; a store always completes.
REQ-030 Timeout counter runs in BUSY_x and clears on grant. On reaching TIMEOUT without m_ack: drop m_req, set err, enter RESP, and return ack with rdata=0.
REQ-031 m_ack in IDLE or RESP is ignored.
REQ-032 Simultaneous if_req and mem_req in IDLE are resolved by REQ-022 in that same cycle.

Reset
REQ-033 rst forces the following values regardless of state:
- state=IDLE.
- m_req=0, m_we=0, m_addr=0, m_wdata=0.
- if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0.
- starve_cnt=0, timeout counter=0, err=0.
REQ-034 rst during BUSY_x abandons the transaction with no ack; a later stray m_ack is ignored per REQ-031.

Structure
REQ-035 Shared package pipe_arb_pkg: state encoding, STARVE_LIMIT and TIMEOUT defaults.
REQ-036 One sub-module, pipe_arb_timer: loadable 4-bit timeout counter with an expiry output.
REQ-037 Arbitration FSM, starvation counter and data capture registers are inline in pipe_mem_arbiter.

Verification
REQ-038 if_req only, addr 0x8, memory acks next cycle with 0x2010FFFF -> if_ack 2 cycles after grant, if_rdata=0x2010FFFF, stall_if high until ack.
REQ-039 if_req and mem_req (load, addr 0x4) together in IDLE -> MEM granted first; IF granted on the following IDLE.
REQ-040 mem_req held continuously for 4 transactions with if_req high -> grants MEM,MEM,MEM,IF, with starve_cnt cleared after the IF grant.
REQ-041 if_abort pulsed in BUSY_IF -> m_req completes normally, if_ack stays 0, then IDLE.
REQ-042 Store to 0x10 with m_ack never asserted -> after 15 BUSY cycles err=1, mem_ack pulse with mem_rdata=0, stays sticky until rst.
REQ-043 rst asserted in BUSY_MEM, then m_ack 2 cycles later -> all outputs at reset values, no ack emitted, state remains IDLE.

Source files
------------

// File: rtl/pipe_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_arb_pkg : shared state encoding and defaults for the arbiter    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package pipe_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2,
    ST_RESP     = 2'd3
  } arb_state_t;

  localparam int STARVE_LIMIT_DEF = 3;
  localparam int TIMEOUT_DEF      = 15;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_arb_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_arb_timer : loadable 4-bit timeout counter with expiry flag     |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module pipe_arb_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [3:0] LAST = 4'(LIMIT - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 4'd0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count value LIMIT-1 is reached on the LIMIT-th enabled cycle.
  assign expired_o = en_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/pipe_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_mem_arbiter : IF/MEM arbiter onto one single-port memory        |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module pipe_mem_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_abort,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        err
);

  localparam logic [2:0] STARVE_CMP = 3'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [1:0]  starve_q, starve_d;
  logic        abort_q, abort_d;
  logic        err_q, err_d;
  logic        grant;
  logic        busy;
  logic        expired;

  assign busy = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_MEM);

  pipe_arb_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (grant),
    .en_i      (busy),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    starve_d    = starve_q;
    abort_d     = abort_q;
    err_d       = err_q;
    grant       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req && (({1'b0, starve_q} < STARVE_CMP) || !if_req)) begin
          state_d   = ST_BUSY_MEM;
          grant     = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = mem_we;
          m_addr_d  = mem_addr;
          m_wdata_d = mem_wdata;
          starve_d  = if_req ? sat_inc2(starve_q) : 2'd0;
          abort_d   = 1'b0;
        end else if (if_req) begin
          state_d   = ST_BUSY_IF;
          grant     = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = 32'd0;
          starve_d  = 2'd0;
          abort_d   = 1'b0;
        end else begin
          starve_d = 2'd0;
        end
      end
      ST_BUSY_IF: begin
        // A branch seen at any point during the fetch kills its delivery.
        abort_d = abort_q | if_abort;
        if (m_ack || expired) begin
          state_d    = ST_RESP;
          m_req_d    = 1'b0;
          if_rdata_d = m_ack ? m_rdata : 32'd0;
          if_ack_d   = ~(abort_q | if_abort);
          err_d      = err_q | ~m_ack;
        end
      end
      ST_BUSY_MEM: begin
        if (m_ack || expired) begin
          state_d     = ST_RESP;
          m_req_d     = 1'b0;
          mem_rdata_d = m_ack ? m_rdata : 32'd0;
          mem_ack_d   = 1'b1;
          err_d       = err_q | ~m_ack;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= 32'd0;
      m_wdata_q   <= 32'd0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      starve_q    <= 2'd0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      starve_q    <= starve_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
    end
  end

  // An abort arriving in the response cycle still suppresses the ack.
  assign if_ack    = if_ack_q & ~if_abort;
  assign if_rdata  = if_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;
  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_mem_arbiter : directed vector bench for pipe_mem_arbiter     |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_pipe_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_abort, mem_req, mem_we, m_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, m_rdata;
  logic        if_ack, mem_ack, stall_if, stall_mem, m_req, m_we, err;
  logic [31:0] if_rdata, mem_rdata, m_addr, m_wdata;

  pipe_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_abort  (if_abort),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ack     (m_ack),
    .m_rdata   (m_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_abort;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic [134:0] exp;
  } vec_t;

  localparam logic [31:0] DA = 32'h2010_FFFF;
  localparam logic [31:0] DB = 32'hAAAA_5555;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[16];

  logic [134:0] act;
  assign act = {if_ack, if_rdata, mem_ack, mem_rdata, m_req, m_we, m_addr, m_wdata,
                stall_if, stall_mem, err};

  function automatic logic [134:0] eo(input logic ia, input logic [31:0] ird,
                                      input logic ma, input logic [31:0] mrd,
                                      input logic rq, input logic we,
                                      input logic [31:0] ad, input logic [31:0] wd,
                                      input logic si, input logic sm, input logic er);
    return {ia, ird, ma, mrd, rq, we, ad, wd, si, sm, er};
  endfunction

  task automatic chk(input string nm, input logic [134:0] got, input logic [134:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'd0; if_abort = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
    m_ack = 1'b0; m_rdata = 32'd0;
  endtask

  initial begin
    logic [31:0] grants[5];
    int ngr;
    int busy_cnt;
    int cyc;

    // if_req,addr,abort,mem_req,we,maddr,wdata,m_ack,m_rdata, expected outputs
    vecs[0]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,  eo(0, 32'h0,  0, 32'h0, 0, 0, 32'h00, 32'h0, 0, 0, 0)};
    vecs[1]  = '{1'b1, 32'h08, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,  eo(0, 32'h0,  0, 32'h0, 0, 0, 32'h00, 32'h0, 1, 0, 0)};
    vecs[2]  = '{1'b1, 32'h08, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, DA,     eo(0, 32'h0,  0, 32'h0, 1, 0, 32'h08, 32'h0, 1, 0, 0)};
    vecs[3]  = '{1'b1, 32'h08, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,  eo(1, DA,     0, 32'h0, 0, 0, 32'h08, 32'h0, 0, 0, 0)};
    vecs[4]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,  eo(0, DA,     0, 32'h0, 0, 0, 32'h08, 32'h0, 0, 0, 0)};
    vecs[5]  = '{1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0,  eo(0, DA,     0, 32'h0, 0, 0, 32'h08, 32'h0, 1, 1, 0)};
    vecs[6]  = '{1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, DB,     eo(0, DA,     0, 32'h0, 1, 0, 32'h04, 32'h0, 1, 1, 0)};
    vecs[7]  = '{1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0,  eo(0, DA,     1, DB,    0, 0, 32'h04, 32'h0, 1, 0, 0)};
    vecs[8]  = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,  eo(0, DA,     0, DB,    0, 0, 32'h04, 32'h0, 1, 0, 0)};
    vecs[9]  = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h13, eo(0, DA,     0, DB,    1, 0, 32'h20, 32'h0, 1, 0, 0)};
    vecs[10] = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,  eo(1, 32'h13, 0, DB,    0, 0, 32'h20, 32'h0, 0, 0, 0)};
    vecs[11] = '{1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,  eo(0, 32'h13, 0, DB,    0, 0, 32'h20, 32'h0, 1, 0, 0)};
    vecs[12] = '{1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,  eo(0, 32'h13, 0, DB,    1, 0, 32'h40, 32'h0, 1, 0, 0)};
    vecs[13] = '{1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77, eo(0, 32'h13, 0, DB,    1, 0, 32'h40, 32'h0, 1, 0, 0)};
    vecs[14] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,  eo(0, 32'h77, 0, DB,    0, 0, 32'h40, 32'h0, 0, 0, 0)};
    vecs[15] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,  eo(0, 32'h77, 0, DB,    0, 0, 32'h40, 32'h0, 0, 0, 0)};

    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if_req = vecs[i].if_req;   if_addr = vecs[i].if_addr;   if_abort = vecs[i].if_abort;
      mem_req = vecs[i].mem_req; mem_we = vecs[i].mem_we;     mem_addr = vecs[i].mem_addr;
      mem_wdata = vecs[i].mem_wdata; m_ack = vecs[i].m_ack;   m_rdata = vecs[i].m_rdata;
      #1;
      chk($sformatf("vec%0d", i), act, vecs[i].exp);
      @(negedge clk);
    end

    // Starvation: both requesters held, memory acks on first busy cycle.
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h200;
    mem_req = 1'b1; mem_addr = 32'h100;
    ngr = 0;
    cyc = 0;
    while (ngr < 5 && cyc < 40) begin
      #1;
      m_ack   = m_req;
      m_rdata = m_req ? (32'h5500_0000 | m_addr) : 32'd0;
      if (m_req) begin
        grants[ngr] = m_addr;
        ngr++;
      end
      cyc++;
      @(negedge clk);
    end
    m_ack = 1'b0; m_rdata = 32'd0;
    chk("starve_grants_seen", 135'(ngr), 135'd5);
    chk("starve_g0", 135'(grants[0]), 135'h100);
    chk("starve_g1", 135'(grants[1]), 135'h100);
    chk("starve_g2", 135'(grants[2]), 135'h100);
    chk("starve_g3", 135'(grants[3]), 135'h200);
    chk("starve_g4_after_clear", 135'(grants[4]), 135'h100);
    #1;
    chk("starve_last_ack", 135'({mem_ack, mem_rdata}), 135'({1'b1, 32'h5500_0100}));
    idle_inputs();
    @(negedge clk);

    // Store that never gets m_ack.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    busy_cnt = 0;
    cyc = 0;
    #1;
    while (m_req && cyc < 40) begin
      if (busy_cnt == 0)
        chk("to_cmd", 135'({m_we, m_addr, m_wdata}), 135'({1'b1, 32'h10, 32'hDEAD_BEEF}));
      busy_cnt++;
      cyc++;
      @(negedge clk);
      #1;
    end
    chk("to_busy_cycles", 135'(busy_cnt), 135'd15);
    chk("to_resp", 135'({mem_ack, mem_rdata, err}), 135'({1'b1, 32'h0, 1'b1}));
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    chk("to_err_sticky", 135'({mem_ack, err}), 135'({1'b0, 1'b1}));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("to_err_cleared", 135'(err), 135'd0);

    // Reset in BUSY_MEM followed by a stray m_ack.
    @(negedge clk);
    mem_req = 1'b1; mem_addr = 32'h30;
    @(negedge clk);
    #1;
    chk("rb_busy", 135'({m_req, m_addr}), 135'({1'b1, 32'h30}));
    rst = 1'b1;
    mem_req = 1'b0; mem_addr = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_ack   = (k == 1);
      m_rdata = (k == 1) ? 32'hFFFF_FFFF : 32'h0;
      #1;
      chk($sformatf("rb_quiet%0d", k), act, 135'd0);
      @(negedge clk);
    end
    m_ack = 1'b0; m_rdata = 32'd0;
    if_req = 1'b1; if_addr = 32'h60;
    @(negedge clk);
    #1;
    chk("rb_idle_grant", 135'({m_req, m_addr}), 135'({1'b1, 32'h60}));
    m_ack = 1'b1; m_rdata = 32'h1234_5678;
    @(negedge clk);
    m_ack = 1'b0; m_rdata = 32'd0;
    if_abort = 1'b1;
    #1;
    chk("abort_in_resp", 135'({if_ack, if_rdata, stall_if}), 135'({1'b0, 32'h1234_5678, 1'b1}));
    idle_inputs();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
